// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional statistics counters are enabled with DM_ARB_STATS_EN.
package dm_arb_pkg;

  localparam int unsigned DM_WORDS = 128;
  localparam int unsigned STAT_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } req_id_e;

  // Saturating increment for the statistics counters
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way round-robin picker; holds the last_grant pointer.
// Used by dm_arbiter (DM_ARB_STATS_EN has no effect here).
module dm_arb_rr
  import dm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant_c
);

  req_id_e r_last_grant;

  // On a conflict the requester that did not win last time goes first
  always_comb begin
    o_grant_c = i_req;
    if (i_req == 2'b11) begin
      o_grant_c = (r_last_grant == DBG) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= DBG;
    end else if (i_update) begin
      r_last_grant <= o_grant_c[1] ? DBG : CPU;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the single-ported data memory between the CPU MEM stage and a debug port.
// Define DM_ARB_STATS_EN to add grant/conflict statistics outputs.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_cpu_grants,
  output logic [STAT_W-1:0] stat_dbg_grants,
  output logic [STAT_W-1:0] stat_conflicts
`endif
);

  localparam int unsigned CNT_W = 3;

  state_e            r_state;
  req_id_e           r_winner;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic [1:0]        w_rr_req;
  logic [1:0]        w_grant;
  logic              w_rr_update;

  // Outside IDLE the picker sees only the winner so RESP commits the right pointer
  assign w_rr_req    = (r_state == IDLE) ? {dbg_req, cpu_req}
                                         : ((r_winner == DBG) ? 2'b10 : 2'b01);
  assign w_rr_update = (r_state == RESP);

  dm_arb_rr u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_rr_req),
    .i_update  (w_rr_update),
    .o_grant_c (w_grant)
  );

  // Access sequencer: grant/latch, one-cycle strobe, latency wait, ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_winner    <= CPU;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_winner    <= w_grant[1] ? DBG : CPU;
            r_we        <= w_grant[1] ? dbg_we : cpu_we;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_grant[1] ? dbg_we : cpu_we;
            r_mem_addr  <= w_grant[1] ? dbg_addr : cpu_addr;
            r_mem_wdata <= w_grant[1] ? dbg_wdata : cpu_wdata;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_cnt    <= CNT_W'(MEM_LAT);
          r_state  <= WAIT;
        end
        WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            if (r_winner == DBG) begin
              r_dbg_ack <= 1'b1;
              if (!r_we) r_dbg_rdata <= mem_rdata;
            end else begin
              r_cpu_ack <= 1'b1;
              if (!r_we) r_cpu_rdata <= mem_rdata;
            end
            r_cnt   <= '0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          r_cpu_ack <= 1'b0;
          r_dbg_ack <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_stall = cpu_req & ~r_cpu_ack;

`ifdef DM_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_cpu;
  logic [STAT_W-1:0] r_stat_dbg;
  logic [STAT_W-1:0] r_stat_conf;

  // Grants are counted at completion, conflicts per IDLE cycle with both requests up
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_cpu  <= '0;
      r_stat_dbg  <= '0;
      r_stat_conf <= '0;
    end else begin
      if (r_state == RESP && r_winner == CPU) r_stat_cpu <= sat_inc(r_stat_cpu);
      if (r_state == RESP && r_winner == DBG) r_stat_dbg <= sat_inc(r_stat_dbg);
      if (r_state == IDLE && cpu_req && dbg_req) r_stat_conf <= sat_inc(r_stat_conf);
    end
  end

  assign stat_cpu_grants = r_stat_cpu;
  assign stat_dbg_grants = r_stat_dbg;
  assign stat_conflicts  = r_stat_conf;
`endif

endmodule
